count_event_monitor: RTL
========================

# count_event_monitor

Downstream consumer of the 8-bit up/down counter output. Samples the count each enabled cycle, classifies each transition against the previous sample, and reports exceptional transitions as coded events through a small valid/ready FIFO. Events are wrap-around, illegal step, and threshold crossing, plus an optional stall. Its sink is the checker/scoreboard logic or a status register block.

## Interface
- WIDTH, 8, count width; matches counter output.
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.
- HI_THRESH, 8'hF0, upper threshold.
- LO_THRESH, 8'h10, lower threshold.
- STALL_LIMIT, 16, consecutive unchanged samples that raise a stall event; only with COUNT_MON_STALL_EN.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- sample_en  input  1  count_in is valid this cycle.
- count_in  input  WIDTH  counter value being monitored.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event.
- evt_code  output  3  head event code: 1 WRAP_UP, 2 WRAP_DN, 3 STEP_ERR, 4 HI_CROSS, 5 LO_CROSS, 6 STALL.
- evt_count  output  WIDTH  count_in value of the sample that raised the head event.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  occupied entries.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.

## Operation
- FSM states:
  - PRIME: reset state. The first sample_en stores count_in as prev, raises no event, and moves to TRACK.
  - TRACK: each sample_en compares cur = count_in against prev, then sets prev = cur.
- Classification in TRACK, modulo 2^WIDTH. At most one event per sample, priority top-down:
  - WRAP_UP: prev == all-ones and cur == 0.
  - WRAP_DN: prev == 0 and cur == all-ones.
  - STEP_ERR: cur ∉ {prev, prev+1, prev−1}. A counter reset mid-count from value v ∉ {0, 1, all-ones} yields STEP_ERR with evt_count 0.
  - HI_CROSS: prev < HI_THRESH and cur ≥ HI_THRESH.
  - LO_CROSS: prev > LO_THRESH and cur ≤ LO_THRESH.
  - cur == prev: no event. This covers a counter held in reset.
- Threshold crossings are evaluated only for legal ±1 steps. Comparisons are unsigned.
- FIFO:
  - Show-ahead: evt_code and evt_count are valid whenever evt_valid = 1, and are held stable until popped.
  - A pop occurs when evt_valid && evt_ready.
  - Full with a push and no pop in the same cycle: the new event is dropped and overflow is set to 1 until rst.
  - Full with a push and a pop in the same cycle: both succeed, no drop, level unchanged.
  - Empty with a push and evt_ready = 1: no bypass. The event appears next cycle.
- Holding evt_ready = 0 never stalls sampling. Samples continue to be classified.
- sample_en = 0: prev, FSM state, and the stall counter hold.

## Timing
- Reset values: evt_valid 0, evt_code 0, evt_count 0, fifo_level 0, overflow 0, FSM state PRIME, prev 0, stall counter 0.
- rst takes priority over all activity and discards FIFO contents.
- Latency: a sample at edge N becomes a FIFO push at edge N+1. evt_valid is high after edge N+1 if the FIFO was empty.
- fifo_level and evt_valid are registered and update at the same edge as the push or pop.
- Throughput: one classified sample per cycle, one pop per cycle.

## Configuration
- COUNT_MON_STALL_EN defined:
  - The stall counter increments on each TRACK sample with cur == prev and clears on any change.
  - On reaching STALL_LIMIT it pushes one STALL event (code 6, evt_count = cur).
  - It then saturates with no repeat events until the value changes.
- COUNT_MON_STALL_EN undefined: no stall counter is built, code 6 is never produced, and STALL_LIMIT is ignored.

## Test plan
- Reset, then samples 0x05, 0x06, 0x07 with evt_ready = 1 -> no events, evt_valid stays 0, fifo_level 0.
- Samples 0xFE, 0xFF, 0x00 -> one WRAP_UP with evt_count 0x00. Then 0xFF -> WRAP_DN with evt_count 0xFF.
- Samples 0x0F, 0xEF, 0xF0 -> STEP_ERR (0xEF) then HI_CROSS (0xF0). Then 0x11, 0x10 after re-prime -> LO_CROSS (0x10).
- evt_ready = 0 with 6 STEP_ERR samples -> fifo_level 4 and overflow 1. Drain yields the first 4 events in order. A full+push+pop cycle drops nothing.
- Counter rst asserted mid-count at 0x40 -> STEP_ERR with evt_count 0x00. Repeated 0x00 samples give no further events. With COUNT_MON_STALL_EN, exactly one STALL follows after 16 unchanged samples.
- rst asserted with 3 queued events -> next cycle fifo_level 0, evt_valid 0, overflow 0, FSM in PRIME. The first following sample produces no event.

Source files
------------

// File: rtl/count_event_monitor.sv
// Watches an up/down counter's output, classifies each sampled transition and queues
// exceptional ones (wrap, illegal step, threshold crossing) in a show-ahead event FIFO.
// Define COUNT_MON_STALL_EN to also report a counter stuck for STALL_LIMIT samples.
module count_event_monitor #(
    parameter int                 WIDTH       = 8,
    parameter int                 FIFO_DEPTH  = 4,
    parameter logic [WIDTH-1:0]   HI_THRESH   = 8'hF0,
    parameter logic [WIDTH-1:0]   LO_THRESH   = 8'h10,
    parameter int                 STALL_LIMIT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_en,
    input  logic [WIDTH-1:0]                  count_in,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [2:0]                        evt_code,
    output logic [WIDTH-1:0]                  evt_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = WIDTH + 3;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam logic [2:0] EVT_NONE     = 3'd0;
    localparam logic [2:0] EVT_WRAP_UP  = 3'd1;
    localparam logic [2:0] EVT_WRAP_DN  = 3'd2;
    localparam logic [2:0] EVT_STEP_ERR = 3'd3;
    localparam logic [2:0] EVT_HI_CROSS = 3'd4;
    localparam logic [2:0] EVT_LO_CROSS = 3'd5;
`ifdef COUNT_MON_STALL_EN
    localparam logic [2:0] EVT_STALL    = 3'd6;
    localparam int         SC_W         = $clog2(STALL_LIMIT + 1);
`endif

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] prev_reg;
    logic             push_reg;
    logic [2:0]       push_code_reg;
    logic [WIDTH-1:0] push_count_reg;
    logic [2:0]       cls_code;
    logic [WIDTH-1:0] prev_plus1;
    logic [WIDTH-1:0] prev_minus1;

`ifdef COUNT_MON_STALL_EN
    logic [SC_W-1:0]  stall_cnt_reg;
`endif

    assign prev_plus1  = prev_reg + ONE;
    assign prev_minus1 = prev_reg - ONE;

    // Wraps are tested first so the legal all-ones/zero steps never look like threshold moves.
    always_comb begin
        cls_code = EVT_NONE;
        if (prev_reg == ALL_ONES && count_in == ZERO)
            cls_code = EVT_WRAP_UP;
        else if (prev_reg == ZERO && count_in == ALL_ONES)
            cls_code = EVT_WRAP_DN;
        else if (count_in != prev_reg && count_in != prev_plus1 && count_in != prev_minus1)
            cls_code = EVT_STEP_ERR;
        else if (prev_reg < HI_THRESH && count_in >= HI_THRESH)
            cls_code = EVT_HI_CROSS;
        else if (prev_reg > LO_THRESH && count_in <= LO_THRESH)
            cls_code = EVT_LO_CROSS;
`ifdef COUNT_MON_STALL_EN
        else if (count_in == prev_reg && stall_cnt_reg == SC_W'(STALL_LIMIT - 1))
            cls_code = EVT_STALL;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_PRIME;
            prev_reg       <= '0;
            push_reg       <= 1'b0;
            push_code_reg  <= '0;
            push_count_reg <= '0;
        end else begin
            push_reg <= 1'b0;
            if (sample_en) begin
                prev_reg <= count_in;
                if (state_reg == ST_PRIME) begin
                    state_reg <= ST_TRACK;
                end else if (cls_code != EVT_NONE) begin
                    push_reg       <= 1'b1;
                    push_code_reg  <= cls_code;
                    push_count_reg <= count_in;
                end
            end
        end
    end

`ifdef COUNT_MON_STALL_EN
    // Saturates at the limit so a long stall reports only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (sample_en && state_reg == ST_TRACK) begin
            if (count_in != prev_reg)
                stall_cnt_reg <= '0;
            else if (stall_cnt_reg != SC_W'(STALL_LIMIT))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end
`endif

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic             valid_reg;
    logic             overflow_reg;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;

    assign fifo_full = (level_reg == LVL_W'(FIFO_DEPTH));
    assign do_pop    = valid_reg && evt_ready;
    assign do_push   = push_reg && (!fifo_full || do_pop);

    always_comb begin
        level_next = level_reg;
        if (do_push && !do_pop)
            level_next = level_reg + 1'b1;
        else if (!do_push && do_pop)
            level_next = level_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[wr_ptr_reg] <= {push_code_reg, push_count_reg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
            valid_reg <= (level_next != '0);
            if (push_reg && fifo_full && !do_pop)
                overflow_reg <= 1'b1;
        end
    end

    // Head is forced to zero while empty so stale entries never leak onto the outputs.
    assign evt_valid  = valid_reg;
    assign evt_code   = valid_reg ? mem[rd_ptr_reg][ENT_W-1:WIDTH] : 3'd0;
    assign evt_count  = valid_reg ? mem[rd_ptr_reg][WIDTH-1:0] : '0;
    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;

endmodule
